// File: rtl/pll_lock_rst_seq_pkg.sv
// Shared definitions for the PLL lock / reset sequencer and the camera-side
// blocks: the sequencer state encoding, default 50 MHz cycle counts, the
// OV7670 power-up timing constants and the decoded-output payload.
package pll_lock_rst_seq_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned SEQ_CNT_W  = 17;

    // Microseconds to clk cycles at CLK_HZ.
    function automatic int unsigned us_to_cyc(input int unsigned us);
        return us * (CLK_HZ / 1_000_000);
    endfunction

    // OV7670 power-up timing, also used by the SCCB configuration block.
    localparam int unsigned OV7670_PWDN_CYC   = us_to_cyc(1000);
    localparam int unsigned OV7670_RST_CYC    = us_to_cyc(1000);
    localparam int unsigned OV7670_SETTLE_CYC = us_to_cyc(1000);

    // Sequencer defaults.
    localparam int unsigned LOCK_STABLE_CYC_DEF = 1024;
    localparam int unsigned SYS_RST_CYC_DEF     = 16;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_LOCK_QUAL  = 3'd1,
        ST_SYS_RST    = 3'd2,
        ST_CAM_PWDN   = 3'd3,
        ST_CAM_RST    = 3'd4,
        ST_CAM_SETTLE = 3'd5,
        ST_READY      = 3'd6
    } seq_state_e;

    // Level outputs that are a pure function of the sequencer state.
    typedef struct packed {
        logic sys_rst;
        logic cam_pwdn;
        logic cam_rst_n;
        logic ready;
    } seq_outs_t;

    // State to level-output decode.
    function automatic seq_outs_t decode_outs(input seq_state_e st);
        seq_outs_t o;
        o = '{sys_rst: 1'b1, cam_pwdn: 1'b1, cam_rst_n: 1'b0, ready: 1'b0};
        case (st)
            ST_CAM_PWDN:   o = '{sys_rst: 1'b0, cam_pwdn: 1'b1, cam_rst_n: 1'b0, ready: 1'b0};
            ST_CAM_RST:    o = '{sys_rst: 1'b0, cam_pwdn: 1'b0, cam_rst_n: 1'b0, ready: 1'b0};
            ST_CAM_SETTLE: o = '{sys_rst: 1'b0, cam_pwdn: 1'b0, cam_rst_n: 1'b1, ready: 1'b0};
            ST_READY:      o = '{sys_rst: 1'b0, cam_pwdn: 1'b0, cam_rst_n: 1'b1, ready: 1'b1};
            default:       o = '{sys_rst: 1'b1, cam_pwdn: 1'b1, cam_rst_n: 1'b0, ready: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_rst_seq_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with async active-low reset.
//   clk   : destination clock
//   rst_n : async active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: qualifies the PLL lock flag, then sequences the 50 MHz
// datapath reset, the OV7670 PWDN/RESET# power-up and the SCCB config start.
// Loss of lock after qualification restarts everything and sets lock_lost.
//   clk        : 50 MHz PLL output, the only clock
//   rst_n      : async active-low reset
//   pll_locked : PLL lock flag, asynchronous to clk
//   sys_rst    : active-high reset for downstream logic
//   cam_pwdn   : OV7670 PWDN, active high
//   cam_rst_n  : OV7670 RESET#, active low
//   cfg_start  : one-cycle SCCB configuration start pulse
//   ready      : sequence complete, held while lock holds
//   lock_lost  : sticky lock-loss flag, cleared only by rst_n
module pll_lock_rst_seq
    import pll_lock_rst_seq_pkg::*;
#(
    parameter int unsigned CNT_W           = SEQ_CNT_W,
    parameter int unsigned LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
    parameter int unsigned SYS_RST_CYC     = SYS_RST_CYC_DEF,
    parameter int unsigned CAM_PWDN_CYC    = OV7670_PWDN_CYC,
    parameter int unsigned CAM_RST_CYC     = OV7670_RST_CYC,
    parameter int unsigned CAM_SETTLE_CYC  = OV7670_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic sys_rst,
    output logic cam_pwdn,
    output logic cam_rst_n,
    output logic cfg_start,
    output logic ready,
    output logic lock_lost
);

    logic             lk_s;
    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] last_cnt;
    logic             lock_lost_nxt;
    logic             cfg_start_nxt;
    seq_outs_t        outs_nxt;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Terminal counter value of the current timed state.
    always_comb begin
        last_cnt = '0;
        case (state)
            ST_LOCK_QUAL:  last_cnt = CNT_W'(LOCK_STABLE_CYC - 1);
            ST_SYS_RST:    last_cnt = CNT_W'(SYS_RST_CYC - 1);
            ST_CAM_PWDN:   last_cnt = CNT_W'(CAM_PWDN_CYC - 1);
            ST_CAM_RST:    last_cnt = CNT_W'(CAM_RST_CYC - 1);
            ST_CAM_SETTLE: last_cnt = CNT_W'(CAM_SETTLE_CYC - 1);
            default:       last_cnt = '0;
        endcase
    end

    // Next state, counter and next-state output decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lock_lost_nxt = lock_lost;

        case (state)
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    state_nxt = ST_LOCK_QUAL;
                end
            end
            ST_READY: begin
                if (!lk_s) begin
                    state_nxt     = ST_WAIT_LOCK;
                    lock_lost_nxt = 1'b1;
                end
            end
            default: begin
                // Lock loss takes priority over a coinciding expiry.
                if (!lk_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    if (state != ST_LOCK_QUAL) begin
                        lock_lost_nxt = 1'b1;
                    end
                end else if (cnt == last_cnt) begin
                    case (state)
                        ST_LOCK_QUAL:  state_nxt = ST_SYS_RST;
                        ST_SYS_RST:    state_nxt = ST_CAM_PWDN;
                        ST_CAM_PWDN:   state_nxt = ST_CAM_RST;
                        ST_CAM_RST:    state_nxt = ST_CAM_SETTLE;
                        ST_CAM_SETTLE: state_nxt = ST_READY;
                        default:       state_nxt = ST_WAIT_LOCK;
                    endcase
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase

        if (state_nxt != state || state_nxt == ST_WAIT_LOCK) begin
            cnt_nxt = '0;
        end

        outs_nxt      = decode_outs(state_nxt);
        cfg_start_nxt = (state_nxt == ST_READY) && (state != ST_READY);
    end

    // State and phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs, updated on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst   <= 1'b1;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            ready     <= 1'b0;
            cfg_start <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            sys_rst   <= outs_nxt.sys_rst;
            cam_pwdn  <= outs_nxt.cam_pwdn;
            cam_rst_n <= outs_nxt.cam_rst_n;
            ready     <= outs_nxt.ready;
            cfg_start <= cfg_start_nxt;
            lock_lost <= lock_lost_nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Self-checking bench for pll_lock_rst_seq with small cycle counts.
// The reference model tracks the synchronizer pipeline and the elapsed
// time since lock-qualification start; outputs follow from thresholds.
module tb_pll_lock_rst_seq;

    localparam int unsigned L   = 4;
    localparam int unsigned S   = 2;
    localparam int unsigned P   = 3;
    localparam int unsigned R   = 3;
    localparam int unsigned T   = 5;
    localparam int          TOT = int'(L + S + P + R + T);

    logic clk = 1'b0;
    logic rst_n;
    logic pll_locked;
    logic sys_rst;
    logic cam_pwdn;
    logic cam_rst_n;
    logic cfg_start;
    logic ready;
    logic lock_lost;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit m_s1;
    bit m_s2;
    bit m_active;
    int m_t;
    bit m_lost;

    pll_lock_rst_seq #(
        .CNT_W           (4),
        .LOCK_STABLE_CYC (L),
        .SYS_RST_CYC     (S),
        .CAM_PWDN_CYC    (P),
        .CAM_RST_CYC     (R),
        .CAM_SETTLE_CYC  (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sys_rst    (sys_rst),
        .cam_pwdn   (cam_pwdn),
        .cam_rst_n  (cam_rst_n),
        .cfg_start  (cfg_start),
        .ready      (ready),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_outs();
        return {sys_rst, cam_pwdn, cam_rst_n, cfg_start, ready, lock_lost};
    endfunction

    // {sys_rst, cam_pwdn, cam_rst_n, cfg_start, ready, lock_lost}
    function automatic logic [5:0] model_outs();
        if (!m_active) begin
            return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_lost};
        end
        return {m_t < int'(L + S), m_t < int'(L + S + P), m_t >= int'(L + S + P + R),
                m_t == TOT, m_t >= TOT, m_lost};
    endfunction

    task automatic model_reset();
        m_s1     = 1'b0;
        m_s2     = 1'b0;
        m_active = 1'b0;
        m_t      = 0;
        m_lost   = 1'b0;
    endtask

    // One clock edge of the reference model.
    task automatic model_edge();
        bit lk;
        if (!rst_n) begin
            model_reset();
        end else begin
            lk   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            if (!m_active) begin
                if (lk) begin
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end else if (!lk) begin
                if (m_t >= int'(L)) m_lost = 1'b1;
                m_active = 1'b0;
            end else if (m_t <= TOT) begin
                m_t++;
            end
        end
    endtask

    // Advance one edge and compare every output against the model.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_async", 32'(dut_outs()), 32'(6'b110000));
        tick();
        tick();
        #2;
        rst_n = 1'b1;
    endtask

    // Run 40 edges with lock held; report first cfg_start edge and pulse count.
    task automatic run_until_cfg(output int edge_at, output int pulses);
        edge_at = -1;
        pulses  = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (cfg_start === 1'b1) begin
                pulses++;
                if (edge_at < 0) edge_at = e;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int f_sys, f_pwdn, f_rstn, f_rdy, c_edge, c_cnt;
        bit glitch_ok;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        model_reset();
        #12;
        check_eq("reset_vals", 32'(dut_outs()), 32'(6'b110000));
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean power-up: edge numbers of each transition.
        pll_locked = 1'b1;
        f_sys = -1; f_pwdn = -1; f_rstn = -1; f_rdy = -1; c_edge = -1; c_cnt = 0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (f_sys  < 0 && sys_rst   === 1'b0) f_sys  = e;
            if (f_pwdn < 0 && cam_pwdn  === 1'b0) f_pwdn = e;
            if (f_rstn < 0 && cam_rst_n === 1'b1) f_rstn = e;
            if (f_rdy  < 0 && ready     === 1'b1) f_rdy  = e;
            if (cfg_start === 1'b1) begin
                c_cnt++;
                if (c_edge < 0) c_edge = e;
            end
        end
        check_eq("sys_rst_fall", 32'(f_sys), 32'd8);
        check_eq("pwdn_fall", 32'(f_pwdn), 32'd11);
        check_eq("cam_rst_rise", 32'(f_rstn), 32'd14);
        check_eq("cfg_edge", 32'(c_edge), 32'd19);
        check_eq("cfg_pulses", 32'(c_cnt), 32'd1);
        check_eq("ready_edge", 32'(f_rdy), 32'd19);
        check_eq("ready_hold", 32'(ready), 32'd1);

        // Short lock glitch is rejected without flagging lock loss.
        pll_locked = 1'b0;
        async_reset();
        repeat (3) tick();
        pll_locked = 1'b1;
        glitch_ok  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) pll_locked = 1'b0;
            tick();
            if (sys_rst !== 1'b1 || lock_lost !== 1'b0) glitch_ok = 1'b0;
        end
        check_eq("glitch_quiet", 32'(glitch_ok), 32'd1);
        pll_locked = 1'b1;
        run_until_cfg(c_edge, c_cnt);
        check_eq("glitch_cfg_edge", 32'(c_edge), 32'd19);
        check_eq("glitch_lost", 32'(lock_lost), 32'd0);

        // Lock loss during CAM_RST, then a full rerun.
        pll_locked = 1'b0;
        async_reset();
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (12) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        check_eq("camrst_loss", 32'(dut_outs()), 32'(6'b110001));
        pll_locked = 1'b1;
        run_until_cfg(c_edge, c_cnt);
        check_eq("rerun_cfg_edge", 32'(c_edge), 32'd19);
        check_eq("rerun_cfg_pulses", 32'(c_cnt), 32'd1);
        check_eq("rerun_lost_sticky", 32'(lock_lost), 32'd1);

        // lk_s falls in the last CAM_SETTLE cycle: no cfg_start.
        pll_locked = 1'b0;
        async_reset();
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (17) tick();
        pll_locked = 1'b0;
        c_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cfg_start === 1'b1) c_cnt++;
        end
        check_eq("settle_loss_cfg", 32'(c_cnt), 32'd0);
        check_eq("settle_loss_outs", 32'(dut_outs()), 32'(6'b110001));

        // Async reset mid CAM_PWDN with lock held.
        pll_locked = 1'b0;
        async_reset();
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        async_reset();
        run_until_cfg(c_edge, c_cnt);
        check_eq("post_rst_cfg_edge", 32'(c_edge), 32'd19);
        check_eq("post_rst_lost", 32'(lock_lost), 32'd0);

        // Random lock activity with occasional async resets.
        for (int seg = 0; seg < 120; seg++) begin
            int hold;
            pll_locked = 1'($urandom_range(0, 1));
            hold       = int'($urandom_range(1, 30));
            if ($urandom_range(0, 19) == 0) async_reset();
            repeat (hold) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_rst_seq.md
Name: pll_lock_rst_seq

Overview:
- Power-up and reset sequencer placed directly downstream of the 25→50 MHz PLL.
- Consumes the PLL `locked` output and qualifies it for a minimum stable time.
- Then produces, in order:
  - a timed system reset for the 50 MHz datapath;
  - the OV7670 PWDN/RESET power-up sequence;
  - a one-cycle start pulse for the SCCB register-configuration block.
- Any loss of lock after qualification returns all outputs to their reset values and restarts the sequence.

Parameters:
- CNT_W, 17, width of the shared phase counter. Every *_CYC value must be ≥1 and ≤2^CNT_W−1.
- LOCK_STABLE_CYC, 1024, cycles the synchronized lock must stay high before it is accepted.
- SYS_RST_CYC, 16, cycles `sys_rst` is held after lock is qualified.
- CAM_PWDN_CYC, 50000, cycles `cam_pwdn`=1 (1 ms at 50 MHz).
- CAM_RST_CYC, 50000, cycles `cam_rst_n`=0 with `cam_pwdn`=0.
- CAM_SETTLE_CYC, 50000, cycles between `cam_rst_n` release and `cfg_start`.

Ports:
- clk, in, 1: 50 MHz PLL `clkout0`; the only clock.
- rst_n, in, 1: asynchronous, active-low reset.
- pll_locked, in, 1: PLL lock flag, treated as asynchronous to `clk`.
- sys_rst, out, 1: active-high reset for downstream 50 MHz logic.
- cam_pwdn, out, 1: OV7670 PWDN, active high.
- cam_rst_n, out, 1: OV7670 RESET#, active low.
- cfg_start, out, 1: one-cycle pulse that starts SCCB configuration.
- ready, out, 1: sequence complete; stays high while lock is held.
- lock_lost, out, 1: sticky flag, set on loss of lock after qualification; cleared only by `rst_n`.

Behaviour:

Synchronization and reset:
- `pll_locked` passes through a 2-FF synchronizer (flops reset to 0). Its output is `lk_s`.
- `rst_n` low asynchronously forces:
  - state = WAIT_LOCK, counter = 0, synchronizer = 0;
  - `sys_rst`=1, `cam_pwdn`=1, `cam_rst_n`=0, `cfg_start`=0, `ready`=0, `lock_lost`=0.

Output timing:
- All outputs are registered.
- They are decoded from the next state, so each output changes on the same edge the state register changes.

States and outputs (sys_rst / cam_pwdn / cam_rst_n / ready):
- WAIT_LOCK (1/1/0/0): counter held at 0. Go to LOCK_QUAL when `lk_s`=1.
- LOCK_QUAL (1/1/0/0): counter increments. `lk_s`=0 → WAIT_LOCK, counter=0, `lock_lost` not set. At counter = LOCK_STABLE_CYC−1 → SYS_RST.
- SYS_RST (1/1/0/0): lasts SYS_RST_CYC cycles → CAM_PWDN.
- CAM_PWDN (0/1/0/0): lasts CAM_PWDN_CYC cycles → CAM_RST.
- CAM_RST (0/0/0/0): lasts CAM_RST_CYC cycles → CAM_SETTLE.
- CAM_SETTLE (0/0/1/0): lasts CAM_SETTLE_CYC cycles → READY.
- READY (0/0/1/1): terminal state while lock is held.

Counter and pulse rules:
- Each timed state lasts exactly N cycles; the counter runs 0..N−1 and is cleared on every state change.
- `cfg_start`=1 only in the first cycle of READY, exactly once per sequence. Re-entry to READY after a lock loss produces a new pulse.

Lock loss:
- `lk_s`=0 in SYS_RST, CAM_PWDN, CAM_RST, CAM_SETTLE or READY causes, on the next edge:
  - state = WAIT_LOCK, counter = 0;
  - outputs return to their WAIT_LOCK values;
  - `lock_lost`=1 (sticky).
- If lock loss coincides with a counter expiry, the lock loss wins.
- If lock loss coincides with READY entry, no `cfg_start` is issued.

Latency:
- Let edge 0 be the first edge at which `pll_locked`=1 is sampled and lock then holds.
- `lk_s`=1 after edge 1; LOCK_QUAL is entered at edge 2.
- READY and `cfg_start` are asserted at edge 2+L+S+P+R+T, where L, S, P, R, T are LOCK_STABLE_CYC, SYS_RST_CYC, CAM_PWDN_CYC, CAM_RST_CYC, CAM_SETTLE_CYC.

Counter width:
- The counter is CNT_W bits unsigned and never wraps, because the parameter limits above guarantee it.

Decomposition:
- Shared package holds:
  - the state enum (7 states, binary encoding, WAIT_LOCK = 0);
  - default cycle constants for 50 MHz;
  - the OV7670 timing constants, reused by the SCCB configuration block.
- One sub-module: `sync_2ff` (1-bit, async active-low reset, reset value parameter). The same module is reused by camera-side blocks.

Test Plan (use L=4, S=2, P=3, R=3, T=5, CNT_W=4 unless stated):
- Release `rst_n`, then raise `pll_locked` and hold it → `sys_rst` falls at edge 8; `cam_pwdn` falls at edge 11; `cam_rst_n` rises at edge 14; `cfg_start`=1 for exactly one cycle at edge 19 and `ready`=1 from edge 19 on.
- `pll_locked` glitches high for 3 cycles then low, then stays high → no `sys_rst` change during the glitch; `lock_lost`=0; sequence completes 19 edges after the final rise.
- Drop `pll_locked` during CAM_RST → 2 edges later all outputs are at reset values and `lock_lost`=1. Restore lock → the full sequence reruns with a second `cfg_start` pulse; `lock_lost` stays 1.
- Drop lock so that `lk_s` falls in the last CAM_SETTLE cycle → no `cfg_start` and `ready`=0; state = WAIT_LOCK.
- Assert `rst_n` low mid CAM_PWDN (not aligned to `clk`) → outputs reach reset values immediately; `lock_lost`=0. After release with lock held, the full sequence completes in 19 edges.
- Default parameters, lock held from reset → `cfg_start` at edge 2+1024+16+150000 = 151042.
